// File: rtl/wb_trace_checker.sv
// Instruction feeder and writeback trace judge for cpu_core.
// Feeds a loaded image and checks nonzero writebacks against a loaded trace.
module wb_trace_checker #(
  parameter int INST_DEPTH  = 4096,
  parameter int TRACE_DEPTH = 1024,
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int CYC_WIDTH   = 24,
  parameter int TIMEOUT     = 100000
) (
  input  logic                                      clk_50M,
  input  logic                                      reset_btn,
  input  logic                                      inst_we,
  input  logic [$clog2(INST_DEPTH)-1:0]             inst_waddr,
  input  logic [DATA_WIDTH-1:0]                     inst_wdata,
  input  logic                                      trace_we,
  input  logic [$clog2(TRACE_DEPTH)-1:0]            trace_waddr,
  input  logic [CYC_WIDTH+RADDR_WIDTH+DATA_WIDTH:0] trace_wdata,
  input  logic [$clog2(TRACE_DEPTH):0]              trace_len,
  input  logic                                      check_cyc,
  input  logic                                      start,
  input  logic                                      mem_stall,
  input  logic [RADDR_WIDTH-1:0]                    wb_reg_waddr,
  input  logic [DATA_WIDTH-1:0]                     wb_reg_wdata,
  output logic [DATA_WIDTH-1:0]                     instr,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      pass,
  output logic [1:0]                                err_code,
  output logic [$clog2(TRACE_DEPTH):0]              err_index,
  output logic [RADDR_WIDTH+DATA_WIDTH-1:0]         err_got,
  output logic [CYC_WIDTH-1:0]                      cycle_count
);
  localparam int IAW = $clog2(INST_DEPTH);
  localparam int TAW = $clog2(TRACE_DEPTH);
  localparam int EW  = 1 + CYC_WIDTH + RADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_PASS, S_FAIL
  } state_t;

  state_t r_state, w_next;

  logic [DATA_WIDTH-1:0] r_imem [INST_DEPTH];
  logic [EW-1:0]         r_tmem [TRACE_DEPTH];

  logic [IAW:0]                       r_pc;
  logic [TAW:0]                       r_tidx;
  logic [DATA_WIDTH-1:0]              r_instr;
  logic [CYC_WIDTH-1:0]               r_cyc;
  logic [1:0]                         r_err_code;
  logic [TAW:0]                       r_err_index;
  logic [RADDR_WIDTH+DATA_WIDTH-1:0]  r_err_got;

  logic [EW-1:0]          w_ent;
  logic                   w_skip;
  logic [CYC_WIDTH-1:0]   w_ecyc;
  logic [RADDR_WIDTH-1:0] w_eaddr;
  logic [DATA_WIDTH-1:0]  w_edata;
  logic                   w_run;
  logic                   w_event;
  logic                   w_mis;
  logic                   w_cmis;
  logic [TAW:0]           w_tidx_nx;
  logic                   w_last;
  logic                   w_tout;
  logic                   w_empty;

  // Memories keep their contents across reset so a rerun needs no reload.
  always_ff @(posedge clk_50M) begin
    if (inst_we && r_state != S_RUN)
      r_imem[inst_waddr] <= inst_wdata;
    if (trace_we && r_state != S_RUN)
      r_tmem[trace_waddr] <= trace_wdata;
  end

  assign w_ent   = r_tmem[r_tidx[TAW-1:0]];
  assign w_skip  = w_ent[EW-1];
  assign w_ecyc  = w_ent[EW-2 -: CYC_WIDTH];
  assign w_eaddr = w_ent[DATA_WIDTH +: RADDR_WIDTH];
  assign w_edata = w_ent[DATA_WIDTH-1:0];

  assign w_run     = (r_state == S_RUN);
  assign w_event   = w_run && (|wb_reg_waddr) && (|wb_reg_wdata);
  assign w_mis     = !w_skip && ((w_eaddr != wb_reg_waddr) ||
                                 (w_edata != wb_reg_wdata));
  assign w_cmis    = !w_skip && check_cyc && (w_ecyc != r_cyc);
  assign w_tidx_nx = r_tidx + (TAW+1)'(1);
  assign w_last    = (w_tidx_nx == trace_len);
  assign w_tout    = (r_cyc >= CYC_WIDTH'(TIMEOUT));
  assign w_empty   = (trace_len == '0);

  always_ff @(posedge clk_50M) begin
    if (reset_btn) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_event) begin
          if (w_mis || w_cmis) w_next = S_FAIL;
          else if (w_last)     w_next = S_PASS;
        end else if (w_tout) begin
          w_next = S_FAIL;
        end
      end
      default: begin
        if (start) w_next = w_empty ? S_PASS : S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      r_pc        <= '0;
      r_tidx      <= '0;
      r_instr     <= '0;
      r_cyc       <= '0;
      r_err_code  <= '0;
      r_err_index <= '0;
      r_err_got   <= '0;
    end else if (!w_run) begin
      if (start) begin
        r_tidx      <= '0;
        r_err_code  <= '0;
        r_err_index <= '0;
        r_err_got   <= '0;
        r_cyc       <= w_empty ? '0 : CYC_WIDTH'(1);
        r_pc        <= w_empty ? '0 : (IAW+1)'(1);
        r_instr     <= w_empty ? '0 : r_imem[0];
      end
    end else begin
      if (w_next == S_RUN) begin
        if (r_cyc != '1) r_cyc <= r_cyc + CYC_WIDTH'(1);
        if (!mem_stall) begin
          // Past the image end feed nops and stop advancing.
          if (r_pc == (IAW+1)'(INST_DEPTH)) begin
            r_instr <= '0;
          end else begin
            r_instr <= r_imem[r_pc[IAW-1:0]];
            r_pc    <= r_pc + (IAW+1)'(1);
          end
        end
      end else begin
        r_instr <= '0;
      end
      if (w_event) begin
        if (w_mis || w_cmis) begin
          r_err_code  <= w_mis ? 2'd1 : 2'd2;
          r_err_index <= r_tidx;
          r_err_got   <= {wb_reg_waddr, wb_reg_wdata};
        end else begin
          r_tidx <= w_tidx_nx;
        end
      end else if (w_tout) begin
        r_err_code  <= 2'd3;
        r_err_index <= r_tidx;
      end
    end
  end

  assign instr       = r_instr;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_PASS) || (r_state == S_FAIL);
  assign pass        = (r_state == S_PASS);
  assign err_code    = r_err_code;
  assign err_index   = r_err_index;
  assign err_got     = r_err_got;
  assign cycle_count = r_cyc;

endmodule
